// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freeze.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_ce,
  output logic        ifid_ce,
  output logic        idex_ce,
  output logic        exmem_ce,
  output logic        memwb_ce,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic {RUN, MWAIT} state_t;

  state_t     state, state_next;
  logic       freeze;
  logic       load_use;
  logic [7:0] wait_cnt;

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    state_next = state;
    pc_ce      = 1'b1;
    ifid_ce    = 1'b1;
    idex_ce    = 1'b1;
    exmem_ce   = 1'b1;
    memwb_ce   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (state)
      RUN:     if (freeze)  state_next = MWAIT;
      MWAIT:   if (!freeze) state_next = RUN;
      default: state_next = RUN;
    endcase

    if (rst || freeze) begin
      pc_ce    = 1'b0;
      ifid_ce  = 1'b0;
      idex_ce  = 1'b0;
      exmem_ce = 1'b0;
      memwb_ce = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID one cycle while a bubble enters EX.
      pc_ce      = 1'b0;
      ifid_ce    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      if (state == RUN && freeze)
        wait_cnt <= 8'd0;
      else if (state == MWAIT && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      // Counter reaches 255 on this edge; the flag stays until reset.
      if (state == MWAIT && wait_cnt == 8'hFE)
        mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_ce && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && flush_count != 32'hFFFF_FFFF)
        flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic        pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce, ifid_flush, idex_flush;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_ce(pc_ce), .ifid_ce(ifid_ce), .idex_ce(idex_ce), .exmem_ce(exmem_ce),
    .memwb_ce(memwb_ce), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: are we inside a memory wait, how many wait cycles
  // have elapsed, and the expected sticky flag and counters.
  bit         m_waiting   = 1'b0;
  int         m_wait_len  = 0;
  bit         m_timeout   = 1'b0;
  longint     m_stall     = 0;
  longint     m_flush     = 0;
  logic [6:0] m_ctl;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  function automatic logic [6:0] expect_ctl();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (rst)                   return 7'b0000000;
    if (mem_req && !mem_ready) return 7'b0000000;
    if (branch_taken)          return 7'b1111111;
    if (lu)                    return 7'b0011101;
    return 7'b1111100;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic [4:0] rd, input logic mrd,
                       input logic br, input logic mreq, input logic mrdy);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    ex_rd = rd; ex_mem_read = mrd; branch_taken = br;
    mem_req = mreq; mem_ready = mrdy;
  endtask

  // Inputs are already applied; check at the falling edge, then advance the model.
  task automatic step(input string tag);
    logic [31:0] es, ef;
    @(negedge clk);
    if (rst) begin
      m_waiting = 1'b0; m_wait_len = 0; m_timeout = 1'b0; m_stall = 0; m_flush = 0;
    end
    m_ctl = expect_ctl();
    check({tag, ".ctl"},
          {25'd0, pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce, ifid_flush, idex_flush},
          {25'd0, m_ctl});
    check({tag, ".timeout"}, {31'd0, mem_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
    es = m_stall[31:0];
    ef = m_flush[31:0];
`else
    es = 32'd0;
    ef = 32'd0;
`endif
    check({tag, ".stall"}, stall_cycles, es);
    check({tag, ".flush"}, flush_count, ef);
    @(posedge clk);
    if (!rst) begin
      if (!m_ctl[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_ctl[1] && m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_waiting) begin
        m_wait_len++;
        if (m_wait_len >= 255) m_timeout = 1'b1;
      end
      if (mem_req && !mem_ready) begin
        if (!m_waiting) m_wait_len = 0;
        m_waiting = 1'b1;
      end else begin
        m_waiting = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset");
    step("reset_hold");
    rst = 1'b0;
    step("idle");

    // Load-use on rs, one cycle, then the stall count is visible.
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
    step("lu_rs");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_lu");

    // Masking: x0 destination, and an unused matching source.
    drive(0, 0, 1, 1, 0, 1, 0, 0, 0);
    step("mask_r0");
    drive(5, 7, 0, 0, 5, 1, 0, 0, 0);
    step("mask_unused");
    drive(5, 9, 1, 1, 9, 0, 0, 0, 0);
    step("mask_not_load");
    drive(3, 9, 1, 1, 9, 1, 0, 0, 0);
    step("lu_rt");

    // Branch and load-use together: branch wins.
    drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
    step("branch_lu");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("after_branch");

    // Three-cycle memory wait with a plain release, then one released under a branch.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("mwait");
    mem_ready = 1'b1;
    step("mwait_release");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) step("mwait2");
    drive(5, 0, 1, 0, 5, 1, 1, 1, 1);
    step("release_branch");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("mwait3");
    drive(5, 0, 1, 0, 5, 1, 0, 1, 1);
    step("release_lu");

    // Long wait: timeout rises after 255 wait cycles and sticks.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step("timeout_wait");
    mem_ready = 1'b1;
    step("timeout_release");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("timeout_sticky");
    rst = 1'b1;
    step("timeout_rst");
    rst = 1'b0;
    step("timeout_cleared");

    // Reset in the middle of a wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("pre_rst_wait");
    rst = 1'b1;
    step("rst_mid_wait");
    rst = 1'b0;
    mem_req = 1'b0;
    step("post_rst_run");

    // Randomized traffic on a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(0, 59) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_mem_read  = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_ready    = 1'($urandom_range(0, 1));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have inputs id_rs and id_rt, each 5 bits: the source register numbers of the instruction in ID.
REQ-004 SHALL have inputs id_use_rs and id_use_rt, each 1 bit: the ID instruction actually reads that source.
REQ-005 SHALL have inputs ex_rd (5 bits) and ex_mem_read (1 bit): the destination of the instruction in EX, and that instruction is a load.
REQ-006 SHALL have input branch_taken, 1 bit: a branch or jump resolved taken in EX.
REQ-007 SHALL have inputs mem_req and mem_ready, 1 bit each: the MEM stage has an access outstanding, and the data is returned or the write is accepted.
REQ-008 SHALL have outputs pc_ce, ifid_ce, idex_ce, exmem_ce and memwb_ce, 1 bit each: clock enables of the pipeline registers.
REQ-009 SHALL have outputs ifid_flush and idex_flush, 1 bit each: synchronous bubble insertion in that pipeline register.
REQ-010 SHALL have output mem_timeout, 1 bit, sticky: a memory wait has exceeded its limit.
REQ-011 SHALL have outputs stall_cycles and flush_count, 32 bits each: performance counters (see Configuration).

Function
REQ-012 SHALL implement a 2-state FSM: RUN and MWAIT.
REQ-013 SHALL define load-use hazard (LU) = ex_mem_read && ex_rd!=0 && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)).
REQ-014 SHALL freeze the pipeline when mem_req && !mem_ready, in either state: all five CE outputs 0 and both flush outputs 0.
REQ-015 SHALL transition RUN->MWAIT on a freeze; MWAIT SHALL hold while mem_req && !mem_ready and SHALL return to RUN when mem_ready=1 or mem_req=0.
REQ-016 SHALL, when not frozen and branch_taken=1, drive all CE outputs 1, ifid_flush=1 and idex_flush=1; this branch case takes priority over LU.
REQ-017 SHALL, when not frozen, branch_taken=0 and LU=1, drive pc_ce=0, ifid_ce=0, idex_flush=1, ifid_flush=0, and idex_ce=exmem_ce=memwb_ce=1, giving exactly one bubble per hazard.
REQ-018 SHALL otherwise drive all CE outputs 1 and both flush outputs 0.
REQ-019 SHALL evaluate the REQ-016 and REQ-017 rules on the MWAIT release cycle (mem_ready=1) exactly as in RUN, with zero added latency.
REQ-020 SHALL make all CE and flush outputs combinational from state and inputs, with no register stage.
REQ-021 SHALL use an 8-bit wait counter: cleared on entry to MWAIT, incremented each MWAIT cycle, and saturating at 255.
REQ-022 SHALL set mem_timeout on the cycle the wait counter reaches 255; it remains 1 until rst, and the freeze continues.
REQ-023 SHALL treat ex_rd=0 as never hazarding, even when ex_mem_read=1.

Reset
REQ-024 SHALL, while rst=1, force all CE outputs 0 and both flush outputs 0.
REQ-025 SHALL, on rst, set state=RUN, wait counter=0, mem_timeout=0, stall_cycles=0 and flush_count=0.
REQ-026 SHALL return to RUN from MWAIT immediately on rst asserted mid-wait, with no residual freeze after deassertion.

Configuration
REQ-027 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cycles on every non-reset cycle with pc_ce=0, saturating at 0xFFFFFFFF.
REQ-028 SHALL, with HAZARD_PERF_CNT_EN defined, increment flush_count on every cycle with ifid_flush=1, saturating at 0xFFFFFFFF.
REQ-029 SHALL, without HAZARD_PERF_CNT_EN, keep both counter ports present, tie them to constant 0, and synthesize no counter flops.

Verification
REQ-030 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1 for 1 cycle -> pc_ce=0, ifid_ce=0, idex_flush=1, exmem_ce=1, and stall_cycles=1 with perf enabled.
REQ-031 SHALL cover LU masking: ex_rd=0 with id_rs=0, or id_use_rs=0 with a match -> all CE outputs 1 and no flush.
REQ-032 SHALL cover branch plus LU in the same cycle: branch_taken=1 and LU=1 -> all CE outputs 1, ifid_flush=idex_flush=1, flush_count+1.
REQ-033 SHALL cover a memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> all CE outputs 0 for 3 cycles, state MWAIT, and all CE outputs 1 on the release cycle.
REQ-034 SHALL cover timeout: mem_ready held 0 for 300 cycles -> mem_timeout rises after 255 MWAIT cycles, the pipeline stays frozen, and mem_timeout clears only on rst.
REQ-035 SHALL cover reset mid-wait: rst pulsed during MWAIT -> all outputs 0 during rst, then state RUN with all CE outputs 1 on the first cycle after release (mem_req=0).
